// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two prioritised write ports and a sequenced clear engine.
// Defining REGFILE_MP_BYPASS_EN adds same-cycle write-to-read forwarding (disabled by default).
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     clear_done
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clr_idx    <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          // Exit on the last index so clr_idx never needs to count past DEPTH-1.
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == ADDR_W'(DEPTH - 1)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state == CLEAR) begin
          if (clr_idx == ADDR_W'(i)) mem[i] <= '0;
        end else if (!(ZERO_REG != 0 && i == 0)) begin
          // wr1 wins a same-address collision with wr0.
          if (wr1_en && wr1_addr == ADDR_W'(i))
            mem[i] <= wr1_data;
          else if (wr0_en && wr0_addr == ADDR_W'(i))
            mem[i] <= wr0_data;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_MP_BYPASS_EN
      if (state == IDLE && wr0_en && wr0_addr == rd_addr[k*ADDR_W +: ADDR_W])
        rd_data[k*DATA_W +: DATA_W] = wr0_data;
      if (state == IDLE && wr1_en && wr1_addr == rd_addr[k*ADDR_W +: ADDR_W])
        rd_data[k*DATA_W +: DATA_W] = wr1_data;
`endif
      if (ZERO_REG != 0 && rd_addr[k*ADDR_W +: ADDR_W] == '0)
        rd_data[k*DATA_W +: DATA_W] = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (DEPTH=32, NUM_RD=2, ZERO_REG=1) against a behavioural model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int DP = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic            wr0_en, wr1_en, clear_req;
  logic [AW-1:0]   wr0_addr, wr1_addr;
  logic [DW-1:0]   wr0_data, wr1_data;
  logic            busy, clear_done;

  regfile_mp #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .clear_req(clear_req), .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  // Reference model: register contents plus the number of clear edges remaining.
  logic [DW-1:0] model [DP];
  bit            m_busy, m_done;
  int            m_left;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input int a);
    if (a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
    if (!m_busy && wr1_en && int'(wr1_addr) == a) return wr1_data;
    if (!m_busy && wr0_en && int'(wr0_addr) == a) return wr0_data;
`endif
    return model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DP; i++) model[i] = '0;
    m_busy = 0; m_done = 0; m_left = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      m_done = 0;
      if (wr0_en && wr0_addr != 0) model[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != 0) model[wr1_addr] = wr1_data;
      if (clear_req) begin m_busy = 1; m_left = DP; end
    end else begin
      model[DP - m_left] = '0;
      m_left--;
      m_done = (m_left == 0);
      if (m_left == 0) m_busy = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NR; k++)
      check($sformatf("rd%0d", k), rd_data[k*DW +: DW], exp_read(int'(rd_addr[k*AW +: AW])));
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("clear_done", {31'd0, clear_done}, {31'd0, m_done});
  endtask

  // Check just before the edge, then advance the model and return 1 time unit after the edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr0_en = 0; wr1_en = 0; clear_req = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt;
    logic [DW-1:0] old12;
    rst = 1; rd_addr = '0; wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
    idle_inputs();
    model_reset();
    cycle(); cycle();
    rst = 0;

    // Reset state on every address and port.
    for (int a = 0; a < DP; a++) begin
      rd_addr = {AW'(DP - 1 - a), AW'(a)};
      cycle();
    end

    // Basic write/read and write to the zero register.
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; cycle();
    wr0_addr = 0; wr0_data = 32'h1234; rd_addr = {AW'(0), AW'(5)}; cycle();
    idle_inputs(); cycle();
    check("addr5", rd_data[0 +: DW], 32'hDEADBEEF);
    check("addr0", rd_data[DW +: DW], 32'h0);

    // Same-address collision, then distinct addresses.
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h1111;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h2222; cycle();
    wr0_addr = 3; wr0_data = 32'h3333; wr1_addr = 4; wr1_data = 32'h4444;
    rd_addr = {AW'(7), AW'(7)}; cycle();
    idle_inputs(); rd_addr = {AW'(4), AW'(3)}; cycle();
    check("collide7", model[7], 32'h2222);
    check("addr3", rd_data[0 +: DW], 32'h3333);
    check("addr4", rd_data[DW +: DW], 32'h4444);

    // Fill all entries, then clear with writes and a repeated request mid-clear.
    for (int a = 0; a < DP; a++) begin
      wr0_en = 1; wr0_addr = AW'(a); wr0_data = $urandom | 32'h1; cycle();
    end
    idle_inputs();
    clear_req = 1; cycle();
    clear_req = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < DP + 8; c++) begin
      rd_addr = {AW'($urandom_range(0, DP - 1)), AW'(9)};
      idle_inputs();
      if (c == 20) begin wr0_en = 1; wr0_addr = 9; wr0_data = 32'h55; end
      if (c == 22) clear_req = 1;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (clear_done) done_cnt++;
      check_all();
      @(posedge clk); model_edge(); #1;
    end
    check("busy_cycles", busy_cnt, DP);
    check("done_pulses", done_cnt, 1);
    for (int a = 0; a < DP; a++) begin
      rd_addr = {AW'(a), AW'(a)}; cycle();
      check("cleared", rd_data[0 +: DW], 32'h0);
    end

    // Reset in the middle of a clear aborts it without a done pulse.
    for (int a = 1; a < DP; a++) begin
      wr1_en = 1; wr1_addr = AW'(a); wr1_data = $urandom | 32'h1; cycle();
    end
    idle_inputs(); clear_req = 1; cycle(); clear_req = 0;
    for (int c = 0; c < 10; c++) cycle();
    rst = 1; model_reset(); #1;
    check("busy_at_rst", {31'd0, busy}, 32'd0);
    cycle();
    rst = 0;
    done_cnt = 0;
    for (int a = 0; a < DP + 4; a++) begin
      rd_addr = {AW'(a), AW'(DP - 1 - a)};
      @(negedge clk);
      if (clear_done) done_cnt++;
      check_all();
      @(posedge clk); model_edge(); #1;
    end
    check("no_done_after_rst", done_cnt, 0);

    // Same-cycle write and read of one address.
    wr0_en = 1; wr0_addr = 12; wr0_data = 32'h0BAD; cycle();
    idle_inputs(); cycle();
    old12 = model[12];
    wr1_en = 1; wr1_addr = 12; wr1_data = 32'hCAFE; rd_addr = {AW'(12), AW'(1)};
    @(negedge clk);
`ifdef REGFILE_MP_BYPASS_EN
    check("bypass12", rd_data[DW +: DW], 32'hCAFE);
`else
    check("bypass12", rd_data[DW +: DW], old12);
`endif
    check_all();
    @(posedge clk); model_edge(); #1;
    idle_inputs(); cycle();
    check("after12", rd_data[DW +: DW], 32'hCAFE);

    // Randomised traffic with occasional clears.
    for (int c = 0; c < 600; c++) begin
      wr0_en = ($urandom_range(0, 2) != 0);
      wr1_en = ($urandom_range(0, 2) == 0);
      wr0_addr = AW'($urandom_range(0, DP - 1));
      wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom_range(0, DP - 1));
      wr0_data = $urandom; wr1_data = $urandom;
      clear_req = ($urandom_range(0, 59) == 0);
      rd_addr = ($urandom_range(0, 2) == 0) ? {wr1_addr, wr0_addr}
                                            : NR*AW'($urandom_range(0, (1 << (NR*AW)) - 1));
      cycle();
    end
    idle_inputs();
    for (int c = 0; c < DP + 2; c++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
